// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle sequencer and the shared datapath/memory port.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_controller_if #(
  parameter int WIDTH_OP = 7
);
  logic [WIDTH_OP-1:0] op;
  logic                mem_ready;
  logic                branch_taken;
  logic                mem_req;
  logic                mem_write;
  logic                adr_src;
  logic                ir_write;
  logic                pc_write;
  logic                reg_write;
  logic [1:0]          result_src;
  logic [1:0]          alu_src_a;
  logic [1:0]          alu_src_b;
  logic [2:0]          alu_op;
  logic [2:0]          imm_src;
  logic                retire;
  logic                illegal;

  modport master (
    input  op, mem_ready, branch_taken,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, retire, illegal
  );

  modport slave (
    output op, mem_ready, branch_taken,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, retire, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: 3-5 cycles per instruction with zero-wait memory.
// Memory stalls hold FETCH/MEMRD/MEMWR (and their strobes) until mem_ready; unknown opcodes lock in TRAP.
module multicycle_controller #(
  parameter int WIDTH_OP = 7
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.master bus
);

  localparam logic [WIDTH_OP-1:0] OP_LOAD   = WIDTH_OP'(7'b0000011);
  localparam logic [WIDTH_OP-1:0] OP_STORE  = WIDTH_OP'(7'b0100011);
  localparam logic [WIDTH_OP-1:0] OP_RTYPE  = WIDTH_OP'(7'b0110011);
  localparam logic [WIDTH_OP-1:0] OP_IALU   = WIDTH_OP'(7'b0010011);
  localparam logic [WIDTH_OP-1:0] OP_LUI    = WIDTH_OP'(7'b0110111);
  localparam logic [WIDTH_OP-1:0] OP_AUIPC  = WIDTH_OP'(7'b0010111);
  localparam logic [WIDTH_OP-1:0] OP_JAL    = WIDTH_OP'(7'b1101111);
  localparam logic [WIDTH_OP-1:0] OP_JALR   = WIDTH_OP'(7'b1100111);
  localparam logic [WIDTH_OP-1:0] OP_BRANCH = WIDTH_OP'(7'b1100011);

  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
    S_EXEC_I, S_LUI, S_JAL, S_JALR, S_JALR_LINK, S_BRANCH, S_ALU_WB, S_TRAP
  } state_t;

  state_t     state_q, state_d;
  logic       mem_req_q, mem_req_d;
  logic       mem_write_q, mem_write_d;
  logic       adr_src_q, adr_src_d;
  logic       pc_write_q, pc_write_d;
  logic       reg_write_q, reg_write_d;
  logic       retire_q, retire_d;
  logic       illegal_q, illegal_d;
  logic [1:0] result_src_q, result_src_d;
  logic [1:0] alu_src_a_q, alu_src_a_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [2:0] imm_dec;
  logic       fetch_done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_IALU:           state_d = S_EXEC_I;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALU_WB;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:    state_d = (bus.op == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:     state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:     state_d = S_FETCH;
      S_MEMWR:     state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_LUI:       state_d = S_ALU_WB;
      S_JAL:       state_d = S_ALU_WB;
      S_JALR:      state_d = S_JALR_LINK;
      S_JALR_LINK: state_d = S_ALU_WB;
      S_BRANCH:    state_d = S_FETCH;
      S_ALU_WB:    state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_BOOT;
    endcase
  end

  // Moore outputs are decoded from the next state so they are registered yet valid in-state.
  always_comb begin
    mem_req_d    = 1'b0;
    mem_write_d  = 1'b0;
    adr_src_d    = 1'b0;
    pc_write_d   = 1'b0;
    reg_write_d  = 1'b0;
    retire_d     = 1'b0;
    illegal_d    = 1'b0;
    result_src_d = 2'b00;
    alu_src_a_d  = 2'b00;
    alu_src_b_d  = 2'b00;
    alu_op_d     = 3'b000;
    case (state_d)
      S_FETCH: begin
        mem_req_d    = 1'b1;
        alu_src_b_d  = 2'b10;
        alu_op_d     = 3'b001;
        result_src_d = 2'b10;
      end
      S_DECODE: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b01;
        alu_op_d    = 3'b001;
      end
      S_MEMADR: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
        alu_op_d    = 3'b001;
      end
      S_MEMRD: begin
        mem_req_d = 1'b1;
        adr_src_d = 1'b1;
      end
      S_MEMWB: begin
        result_src_d = 2'b01;
        reg_write_d  = 1'b1;
        retire_d     = 1'b1;
      end
      S_MEMWR: begin
        mem_req_d   = 1'b1;
        mem_write_d = 1'b1;
        adr_src_d   = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_d = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
      end
      S_LUI: begin
        alu_src_b_d = 2'b01;
        alu_op_d    = 3'b101;
      end
      S_JAL: begin
        pc_write_d  = 1'b1;
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b10;
        alu_op_d    = 3'b001;
      end
      S_JALR: begin
        alu_src_a_d  = 2'b10;
        alu_src_b_d  = 2'b01;
        alu_op_d     = 3'b001;
        result_src_d = 2'b10;
        pc_write_d   = 1'b1;
      end
      S_JALR_LINK: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b10;
        alu_op_d    = 3'b001;
      end
      S_BRANCH: begin
        alu_src_a_d = 2'b10;
        alu_op_d    = 3'b011;
        retire_d    = 1'b1;
      end
      S_ALU_WB: begin
        reg_write_d = 1'b1;
        retire_d    = 1'b1;
      end
      S_TRAP:  illegal_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      adr_src_q    <= 1'b0;
      pc_write_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      retire_q     <= 1'b0;
      illegal_q    <= 1'b0;
      result_src_q <= 2'b00;
      alu_src_a_q  <= 2'b00;
      alu_src_b_q  <= 2'b00;
      alu_op_q     <= 3'b000;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_write_q  <= mem_write_d;
      adr_src_q    <= adr_src_d;
      pc_write_q   <= pc_write_d;
      reg_write_q  <= reg_write_d;
      retire_q     <= retire_d;
      illegal_q    <= illegal_d;
      result_src_q <= result_src_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      alu_op_q     <= alu_op_d;
    end
  end

  always_comb begin
    imm_dec = 3'b000;
    case (bus.op)
      OP_LOAD, OP_IALU, OP_JALR: imm_dec = 3'b001;
      OP_LUI, OP_AUIPC:          imm_dec = 3'b010;
      OP_STORE:                  imm_dec = 3'b011;
      OP_BRANCH:                 imm_dec = 3'b100;
      OP_JAL:                    imm_dec = 3'b101;
      default:                   imm_dec = 3'b000;
    endcase
  end

  // Handshake-dependent strobes stay combinational on mem_ready/branch_taken.
  assign fetch_done     = (state_q == S_FETCH) && bus.mem_ready;
  assign bus.ir_write   = fetch_done;
  assign bus.pc_write   = pc_write_q || fetch_done || ((state_q == S_BRANCH) && bus.branch_taken);
  assign bus.retire     = retire_q || ((state_q == S_MEMWR) && bus.mem_ready);
  assign bus.imm_src    = (state_q == S_BOOT || state_q == S_FETCH || state_q == S_TRAP) ? 3'b000 : imm_dec;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.adr_src    = adr_src_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.illegal    = illegal_q;
  assign bus.result_src = result_src_q;
  assign bus.alu_src_a  = alu_src_a_q;
  assign bus.alu_src_b  = alu_src_b_q;
  assign bus.alu_op     = alu_op_q;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle RV32I core variant. It shares one ALU and one unified instruction/data memory port across the fetch, decode, execute, memory and writeback steps of each instruction. It sits between the instruction register (opcode input) and the shared datapath muxes, register file, PC and memory port. It reuses the single-cycle decoder's `alu_op` / `imm_src` encodings so the existing ALU decoder and immediate extender plug in unchanged.

## Interface
- `WIDTH_OP`, 7: opcode width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: opcode from the instruction register; valid from DECODE onward.
- `mem_ready` in 1: memory has accepted the write, or is returning read data, this cycle.
- `branch_taken` in 1: branch-condition result from the branch unit.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: the request is a store.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR and old_pc.
- `pc_write` out 1: load PC from Result.
- `reg_write` out 1: register file write.
- `result_src` out 2: Result mux select. 00 = ALUOut, 01 = read data, 10 = ALU result.
- `alu_src_a` out 2: ALU A select. 00 = PC, 01 = old_pc, 10 = rs1.
- `alu_src_b` out 2: ALU B select. 00 = rs2, 01 = imm, 10 = constant 4.
- `alu_op` out 3: ALU operation. 000 = R/I-ALU (funct-decoded), 001 = add, 011 = branch compare, 101 = pass B.
- `imm_src` out 3: immediate format. I = 001, U = 010, S = 011, B = 100, J = 101.
- `retire` out 1: one-cycle pulse in the last cycle of each instruction.
- `illegal` out 1: sticky flag for an unsupported opcode.

## Operation
- States: BOOT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, LUI, JAL, JALR, JALR_LINK, BRANCH, ALU_WB, TRAP.
- Any output not listed for a state is 0.
- `imm_src` is decoded from `op` in every state except BOOT, FETCH and TRAP. In those three states it is 000.
- BOOT: all outputs 0. Always goes to FETCH.
- FETCH:
  - Drives `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=001, `result_src`=10.
  - `ir_write` and `pc_write` are asserted only while `mem_ready`=1 (Mealy outputs).
  - Goes to DECODE when `mem_ready`=1; otherwise stays in FETCH.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=001, so ALUOut = old_pc+imm. Next state by opcode:
  - 0000011 / 0100011 → MEMADR.
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 0110111 → LUI.
  - 0010111 → ALU_WB (AUIPC result is already in ALUOut).
  - 1101111 → JAL.
  - 1100111 → JALR.
  - 1100011 → BRANCH.
  - Any other opcode → TRAP.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=001. Goes to MEMRD for a load, MEMWR for a store.
- MEMRD: `mem_req`=1, `adr_src`=1. Goes to MEMWB on `mem_ready`, otherwise holds.
- MEMWB: `result_src`=01, `reg_write`=1, `retire`=1. Goes to FETCH.
- MEMWR: `mem_req`=1, `mem_write`=1, `adr_src`=1. `retire` follows `mem_ready`. Goes to FETCH on `mem_ready`, otherwise holds.
- EXEC_R: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=000. Goes to ALU_WB.
- EXEC_I: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=000. Goes to ALU_WB.
- LUI: `alu_src_b`=01, `alu_op`=101. Goes to ALU_WB.
- JAL: `result_src`=00, `pc_write`=1, `alu_src_a`=01, `alu_src_b`=10, `alu_op`=001 (computes the link value old_pc+4). Goes to ALU_WB.
- JALR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=001, `result_src`=10, `pc_write`=1. Goes to JALR_LINK.
- JALR_LINK: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=001. Goes to ALU_WB.
- BRANCH:
  - Drives `alu_src_a`=10, `alu_src_b`=00, `alu_op`=011, `result_src`=00, `retire`=1.
  - `pc_write` = `branch_taken`.
  - Goes to FETCH.
- ALU_WB: `result_src`=00, `reg_write`=1, `retire`=1. Goes to FETCH.
- TRAP:
  - All strobes are 0 and `illegal`=1.
  - Stays in TRAP until reset. No further memory or register writes occur.

## Timing
- Reset:
  - Asserting `rst_n` low forces BOOT asynchronously, mid-access included.
  - While in reset, every output is 0, including `illegal`, and any outstanding memory request is dropped.
- Release: the first edge after `rst_n` rises enters FETCH. The first `mem_req` is seen one cycle after release.
- Memory handshake:
  - `mem_req`, `adr_src` and `mem_write` stay stable until the edge where `mem_ready` is sampled at 1.
  - Zero-wait operation is allowed: `mem_ready`=1 in the first request cycle completes that access.
  - `mem_ready` is ignored in non-access states.
- Latency with zero-wait memory:
  - Branch and AUIPC: 3 cycles.
  - R-type, I-ALU, LUI, JAL and store: 4 cycles.
  - Load and JALR: 5 cycles.
  - Each wait cycle adds 1.
- `retire` pulses exactly once per instruction and never in TRAP.

## Test plan
- Reset release with `mem_ready` tied to 1, then op=0110011 → states BOOT, FETCH, DECODE, EXEC_R, ALU_WB. `reg_write` and `retire` are high in cycle 4 after FETCH entry; next state is FETCH.
- Load with 2 wait cycles in FETCH and 3 in MEMRD → `mem_req` is held with stable `adr_src` (0, then 1). `ir_write` pulses once. `reg_write` with `result_src`=01 arrives 10 cycles after FETCH entry.
- Branch with `branch_taken`=1, then again with 0 → `pc_write` is 1 and 0 respectively in BRANCH. Both instructions take 3 cycles.
- JALR → `pc_write` with `result_src`=10 in JALR, then the link writeback with `result_src`=00 in ALU_WB. Total 5 cycles.
- op=1111111 → TRAP entered after DECODE. `illegal` stays 1 and all strobes stay 0 for 20 cycles. `rst_n` pulse → BOOT, with `illegal` at 0.
- `rst_n` asserted during MEMWR with `mem_ready`=0 → `mem_req`, `mem_write` and `retire` drop immediately. After release the FSM restarts at FETCH.
